// File: rtl/mem_responder.sv
// Main-memory responder for the dcache big-memory interface: fixed-latency read bursts
// out of an internal word array, single-word writes on any cycle.
module mem_responder #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int MEMADDRBITS = 9,
    parameter int LATENCY     = 1,
    parameter int BURSTBITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDRBITS-1:0]  mem_addr,
    input  logic [DATABITS-1:0]  mem_in,
    output logic [DATABITS-1:0]  mem_out,
    output logic                 mem_valid,
    input  logic [BURSTBITS-1:0] mem_burstlen,
    input  logic                 mem_rdreq,
    input  logic                 mem_wrreq
);

    localparam int DEPTH = 1 << MEMADDRBITS;
    // WAIT holds for LATENCY-1 cycles; counting down from LATENCY-2 to zero covers that.
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [MEMADDRBITS-1:0] IDX_ONE   = 1;
    localparam logic [BURSTBITS-1:0]   BEAT_ONE  = 1;
    localparam logic [3:0]             WAIT_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [MEMADDRBITS-1:0] idx_q, idx_d;
    logic [BURSTBITS-1:0]   cnt_q, cnt_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic                   valid_q, valid_d;
    logic [DATABITS-1:0]    out_q, out_d;
    logic [DATABITS-1:0]    mem_q [DEPTH];
    logic [MEMADDRBITS-1:0] addr_idx;
    logic                   unused_addr_bits;

    assign addr_idx         = mem_addr[MEMADDRBITS+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};
    assign mem_out          = out_q;
    assign mem_valid        = valid_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        valid_d = 1'b0;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rdreq && !mem_wrreq) begin
                    idx_d   = addr_idx;
                    cnt_d   = (mem_burstlen == '0) ? BEAT_ONE : mem_burstlen;
                    wcnt_d  = WAIT_INIT;
                    state_d = (LATENCY > 1) ? S_WAIT : S_BURST;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_BURST;
                end else begin
                    wcnt_d = wcnt_q - WAIT_ONE;
                end
            end
            S_BURST: begin
                // Array read here sees pre-edge contents, so a same-edge write returns old data.
                valid_d = 1'b1;
                out_d   = mem_q[idx_q];
                idx_d   = idx_q + IDX_ONE;
                cnt_d   = cnt_q - BEAT_ONE;
                if (cnt_q == BEAT_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wrreq) begin
            mem_q[addr_idx] <= mem_in;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 1 and 3) checked against a burst-window
// reference model, a directed vector table, and hand-written corner sequences.
module tb_mem_responder;

    localparam int DB = 32;
    localparam int AB = 32;
    localparam int MB = 9;
    localparam int BB = 16;
    localparam int DEPTH = 1 << MB;

    logic          clk = 1'b0;
    logic          reset;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_in;
    logic [BB-1:0] mem_burstlen;
    logic          mem_wrreq;
    logic          rd1, rd3;
    logic [DB-1:0] out1, out3;
    logic          v1, v3;

    always #5 clk = ~clk;

    mem_responder #(.DATABITS(DB), .ADDRBITS(AB), .MEMADDRBITS(MB), .LATENCY(1), .BURSTBITS(BB)) dut1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(out1),
        .mem_valid(v1), .mem_burstlen(mem_burstlen), .mem_rdreq(rd1), .mem_wrreq(mem_wrreq)
    );

    mem_responder #(.DATABITS(DB), .ADDRBITS(AB), .MEMADDRBITS(MB), .LATENCY(3), .BURSTBITS(BB)) dut3 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(out3),
        .mem_valid(v3), .mem_burstlen(mem_burstlen), .mem_rdreq(rd3), .mem_wrreq(mem_wrreq)
    );

    int errors = 0;
    int checks = 0;

    // Reference: a burst is a window of edges [start+lat, start+lat+len-1]; beat k reads word idx+k.
    typedef struct {
        bit busy;
        int start;
        int idx;
        int len;
    } burst_t;

    logic [DB-1:0] ref_mem [DEPTH];
    int            edge_n = 0;
    burst_t        b1, b3;
    bit            ev1, ev3;
    logic [DB-1:0] eo1, eo3;

    typedef struct {
        bit          rst;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [15:0] blen;
        bit          ev;
        logic [31:0] eo;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_dut(input int lat, input bit rd, inout burst_t b, inout bit ev,
                             inout logic [DB-1:0] eo);
        if (reset) begin
            b.busy = 1'b0;
            ev     = 1'b0;
            eo     = '0;
        end else begin
            ev = 1'b0;
            if (b.busy && edge_n >= b.start + lat && edge_n < b.start + lat + b.len) begin
                ev = 1'b1;
                eo = ref_mem[(b.idx + edge_n - b.start - lat) % DEPTH];
            end
            if ((!b.busy || edge_n >= b.start + lat + b.len) && rd && !mem_wrreq) begin
                b.busy  = 1'b1;
                b.start = edge_n;
                b.idx   = int'(mem_addr[MB+1:2]);
                b.len   = (mem_burstlen == 0) ? 1 : int'(mem_burstlen);
            end
        end
    endtask

    // Apply current inputs at the next edge, then compare both instances against the model.
    task automatic cycle();
        model_dut(1, rd1, b1, ev1, eo1);
        model_dut(3, rd3, b3, ev3, eo3);
        if (mem_wrreq) ref_mem[mem_addr[MB+1:2]] = mem_in;
        @(posedge clk);
        #1;
        chk("model_valid_L1", {31'b0, v1}, {31'b0, ev1});
        chk("model_out_L1", out1, eo1);
        chk("model_valid_L3", {31'b0, v3}, {31'b0, ev3});
        chk("model_out_L3", out3, eo3);
        edge_n++;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; mem_wrreq = 1'b0; rd1 = 1'b0; rd3 = 1'b0;
        mem_addr = '0; mem_in = '0; mem_burstlen = '0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        idle_inputs();
        mem_wrreq = 1'b1; mem_addr = a; mem_in = d;
        cycle();
        mem_wrreq = 1'b0;
    endtask

    initial begin
        b1 = '{0, 0, 0, 0};
        b3 = '{0, 0, 0, 0};
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        chk("reset_valid_L1", {31'b0, v1}, 32'd0);
        chk("reset_out_L1", out1, 32'd0);
        chk("reset_out_L3", out3, 32'd0);

        // Preload every word, with random ignored address bits to exercise aliasing.
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[MB+1:2] = i[MB-1:0];
            write_word(a, $urandom);
        end

        tbl[0]  = '{1, 0, 0, 32'h0,  32'h0,         16'd0, 0, 32'h0};
        tbl[1]  = '{1, 0, 0, 32'h0,  32'h0,         16'd0, 0, 32'h0};
        tbl[2]  = '{0, 1, 0, 32'h80, 32'h0fff0001,  16'd0, 0, 32'h0};
        tbl[3]  = '{0, 1, 0, 32'h84, 32'h0fff0002,  16'd0, 0, 32'h0};
        tbl[4]  = '{0, 1, 0, 32'h88, 32'h0fff0003,  16'd0, 0, 32'h0};
        tbl[5]  = '{0, 1, 0, 32'h8c, 32'h0fff0004,  16'd0, 0, 32'h0};
        tbl[6]  = '{0, 0, 1, 32'h80, 32'h0,         16'd4, 0, 32'h0};
        tbl[7]  = '{0, 0, 0, 32'h0,  32'h0,         16'd0, 1, 32'h0fff0001};
        tbl[8]  = '{0, 0, 0, 32'h0,  32'h0,         16'd0, 1, 32'h0fff0002};
        tbl[9]  = '{0, 0, 0, 32'h0,  32'h0,         16'd0, 1, 32'h0fff0003};
        tbl[10] = '{0, 0, 0, 32'h0,  32'h0,         16'd0, 1, 32'h0fff0004};
        tbl[11] = '{0, 0, 0, 32'h0,  32'h0,         16'd0, 0, 32'h0fff0004};
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            reset = tbl[i].rst; mem_wrreq = tbl[i].wr; rd1 = tbl[i].rd;
            mem_addr = tbl[i].addr; mem_in = tbl[i].din; mem_burstlen = tbl[i].blen;
            cycle();
            chk($sformatf("tbl%0d_valid", i), {31'b0, v1}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_out", i), out1, tbl[i].eo);
        end

        // LATENCY=3, len=0 -> exactly one beat three edges after accept.
        idle_inputs();
        rd3 = 1'b1; mem_addr = 32'h84; mem_burstlen = '0;
        cycle();
        rd3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk($sformatf("lat3_valid_k%0d", k), {31'b0, v3}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) chk("lat3_data", out3, 32'h0fff0002);
        end

        // Wrap-around at the top of the array.
        write_word(32'h7fc, 32'hAAAA0001);
        write_word(32'h000, 32'hAAAA0002);
        rd1 = 1'b1; mem_addr = 32'h7fc; mem_burstlen = 16'd2;
        cycle();
        rd1 = 1'b0;
        cycle();
        chk("wrap_beat0_valid", {31'b0, v1}, 32'd1);
        chk("wrap_beat0", out1, 32'hAAAA0001);
        cycle();
        chk("wrap_beat1", out1, 32'hAAAA0002);
        cycle();
        chk("wrap_end_valid", {31'b0, v1}, 32'd0);

        // Simultaneous rdreq+wrreq in IDLE: write wins, held read accepted next edge.
        idle_inputs();
        mem_wrreq = 1'b1; rd1 = 1'b1; mem_addr = 32'h90; mem_in = 32'h12345678; mem_burstlen = 16'd1;
        cycle();
        chk("rw_noaccept_valid", {31'b0, v1}, 32'd0);
        mem_wrreq = 1'b0;
        cycle();
        chk("rw_accept_valid", {31'b0, v1}, 32'd0);
        rd1 = 1'b0;
        cycle();
        chk("rw_beat_valid", {31'b0, v1}, 32'd1);
        chk("rw_beat_data", out1, 32'h12345678);
        cycle();
        chk("rw_end_valid", {31'b0, v1}, 32'd0);

        // Writes during a burst: same-edge word returns old data, later word returns new.
        write_word(32'hA0, 32'h11);
        write_word(32'hA4, 32'h22);
        write_word(32'hA8, 32'h33);
        rd1 = 1'b1; mem_addr = 32'hA0; mem_burstlen = 16'd3;
        cycle();
        rd1 = 1'b0; mem_wrreq = 1'b1; mem_addr = 32'hA8; mem_in = 32'h44;
        cycle();
        chk("rbw_beat0", out1, 32'h11);
        mem_addr = 32'hA4; mem_in = 32'hBEEF;
        cycle();
        chk("rbw_beat1_old", out1, 32'h22);
        mem_wrreq = 1'b0;
        cycle();
        chk("rbw_beat2_new", out1, 32'h44);

        // Reset two beats into a len-8 burst aborts it; array survives.
        idle_inputs();
        rd1 = 1'b1; mem_addr = 32'h100; mem_burstlen = 16'd8;
        cycle();
        rd1 = 1'b0;
        cycle();
        cycle();
        chk("abort_pre_valid", {31'b0, v1}, 32'd1);
        reset = 1'b1;
        cycle();
        chk("abort_rst_valid", {31'b0, v1}, 32'd0);
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk($sformatf("abort_quiet_k%0d", k), {31'b0, v1}, 32'd0);
        end
        rd1 = 1'b1; mem_addr = 32'h80; mem_burstlen = 16'd1;
        cycle();
        rd1 = 1'b0;
        cycle();
        chk("post_reset_valid", {31'b0, v1}, 32'd1);
        chk("post_reset_data", out1, 32'h0fff0001);

        // Level rdreq held across a burst: next burst after one idle edge.
        rd1 = 1'b1; mem_addr = 32'h88; mem_burstlen = 16'd2;
        for (int k = 0; k < 7; k++) cycle();
        rd1 = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            mem_wrreq    = ($urandom_range(0, 3) == 0);
            rd1          = ($urandom_range(0, 2) == 0);
            rd3          = ($urandom_range(0, 2) == 0);
            mem_addr     = $urandom;
            mem_in       = $urandom;
            mem_burstlen = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 300))
                                                        : 16'($urandom_range(0, 6));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
